// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset vector, NOP encoding and the fetch-responder state enum.
package cpu_defs_pkg;

   localparam logic [31:0] STARTADDR = 32'hbfc00000;
   localparam logic [31:0] INST_NOP  = 32'h0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } ifr_state_t;

endpackage

// File: rtl/inst_rom_responder_if.sv
// Fetch request/response channel between the fetch stage (master) and the instruction memory (slave).
interface inst_rom_responder_if;

   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        flush;
   logic        resp_valid;
   logic [31:0] resp_inst;
   logic        resp_err;

   modport master (
      output req_valid, req_addr, flush,
      input  req_ready, resp_valid, resp_inst, resp_err
   );

   modport slave (
      input  req_valid, req_addr, flush,
      output req_ready, resp_valid, resp_inst, resp_err
   );

endinterface

// File: rtl/inst_ram_array.sv
// Single-port synchronous-read instruction array with an independent write port; reads return
// the contents before a same-cycle write to the same word.
module inst_ram_array #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] rd_idx,
   output logic [31:0]           rd_data,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_idx,
   input  logic [31:0]           wr_data
);

   logic [31:0] mem [2**DEPTH_LOG2];

   // rd_data holds its value between reads, so it doubles as the response hold register.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/inst_rom_responder.sv
// Fetch-side instruction memory responder: accepts one word fetch at a time, returns it after
// 1+WAIT_CYCLES cycles, flags bad addresses and drops the outstanding fetch on a pipeline flush.
module inst_rom_responder
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = STARTADDR,
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic                clk,
   input  logic                resetn,
   inst_rom_responder_if.slave bus,
   input  logic                wr_en,
   input  logic [31:0]         wr_addr,
   input  logic [31:0]         wr_data,
   output logic                busy
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_WAIT = WAIT;
   localparam logic [1:0] S_RESP = RESP;

   localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   logic [31:0]           req_off_p0;
   logic [31:0]           wr_off_p0;
   logic                  req_err_p0;
   logic                  wr_err_p0;
   logic [DEPTH_LOG2-1:0] req_idx_p0;
   logic [DEPTH_LOG2-1:0] wr_idx_p0;
   logic                  accept_p0;

   logic [1:0]            state_p1;
   logic [1:0]            state_nx;
   logic [CNT_W-1:0]      cnt_p1;
   logic [CNT_W-1:0]      cnt_nx;
   logic                  err_p1;
   logic [31:0]           rd_data_p1;

   // Stage 0: address decode and accept. Offsets wrap modulo 2^32, so addresses below the base fail the range test.
   assign req_off_p0 = bus.req_addr - ADDR_BASE;
   assign wr_off_p0  = wr_addr - ADDR_BASE;
   assign req_err_p0 = (req_off_p0[1:0] != 2'b00) || (req_off_p0[31:DEPTH_LOG2+2] != '0);
   assign wr_err_p0  = (wr_off_p0[1:0] != 2'b00) || (wr_off_p0[31:DEPTH_LOG2+2] != '0);
   assign req_idx_p0 = req_off_p0[DEPTH_LOG2+1:2];
   assign wr_idx_p0  = wr_off_p0[DEPTH_LOG2+1:2];

   assign bus.req_ready = (state_p1 != S_WAIT) || bus.flush;
   assign accept_p0     = bus.req_valid && bus.req_ready;

   always_comb begin
      state_nx = state_p1;
      cnt_nx   = cnt_p1;
      if (accept_p0) begin
         if (WAIT_CYCLES == 0) begin
            state_nx = S_RESP;
         end else begin
            state_nx = S_WAIT;
            cnt_nx   = CNT_LOAD;
         end
      end else if (bus.flush) begin
         state_nx = S_IDLE;
      end else begin
         case (state_p1)
            S_WAIT: begin
               if (cnt_p1 == '0) begin
                  state_nx = S_RESP;
               end else begin
                  cnt_nx = cnt_p1 - CNT_W'(1);
               end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = state_p1;
         endcase
      end
   end

   // Stage 1: state, wait counter and latched error; array data lands in rd_data_p1.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_p1 <= S_IDLE;
         cnt_p1   <= '0;
         err_p1   <= 1'b0;
      end else begin
         state_p1 <= state_nx;
         cnt_p1   <= cnt_nx;
         if (accept_p0) begin
            err_p1 <= req_err_p0;
         end
      end
   end

   inst_ram_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .rd_en   (accept_p0 && !req_err_p0),
      .rd_idx  (req_idx_p0),
      .rd_data (rd_data_p1),
      .wr_en   (wr_en && !wr_err_p0),
      .wr_idx  (wr_idx_p0),
      .wr_data (wr_data)
   );

   // Response outputs are gated by state so they read as zero outside the pulse and during reset.
   assign bus.resp_valid = (state_p1 == S_RESP);
   assign bus.resp_err   = bus.resp_valid && err_p1;
   assign bus.resp_inst  = (bus.resp_valid && !err_p1) ? rd_data_p1 : INST_NOP;
   assign busy           = (state_p1 == S_WAIT);

endmodule

// File: tb/tb_inst_rom_responder.sv
// Bench for inst_rom_responder: two instances (no wait states and two wait states) share stimulus
// and are checked each cycle against a transaction-level model of the fetch memory.
module tb_inst_rom_responder;

   localparam logic [31:0] BASE  = 32'hbfc00000;
   localparam int          WORDS = 1024;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        flush;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy0, busy1;

   inst_rom_responder_if bus0 ();
   inst_rom_responder_if bus1 ();

   assign bus0.req_valid = req_valid;
   assign bus0.req_addr  = req_addr;
   assign bus0.flush     = flush;
   assign bus1.req_valid = req_valid;
   assign bus1.req_addr  = req_addr;
   assign bus1.flush     = flush;

   inst_rom_responder #(.ADDR_BASE(BASE), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .resetn(resetn), .bus(bus0.slave),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy0)
   );

   inst_rom_responder #(.ADDR_BASE(BASE), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut1 (
      .clk(clk), .resetn(resetn), .bus(bus1.slave),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy1)
   );

   always #5 clk = ~clk;

   logic        o_rdy [2];
   logic        o_busy[2];
   logic        o_vld [2];
   logic        o_err [2];
   logic [31:0] o_inst[2];

   assign o_rdy[0]  = bus0.req_ready;   assign o_rdy[1]  = bus1.req_ready;
   assign o_busy[0] = busy0;            assign o_busy[1] = busy1;
   assign o_vld[0]  = bus0.resp_valid;  assign o_vld[1]  = bus1.resp_valid;
   assign o_err[0]  = bus0.resp_err;    assign o_err[1]  = bus1.resp_err;
   assign o_inst[0] = bus0.resp_inst;   assign o_inst[1] = bus1.resp_inst;

   // Reference model: word memory plus at most one pending fetch per instance with its due cycle.
   int          wait_of[2] = '{0, 2};
   logic [31:0] mem_m[WORDS];
   bit          pend_v  [2];
   int          pend_due[2];
   logic        pend_err[2];
   logic [31:0] pend_inst[2];
   int          cyc;
   int          n_chk;
   int          n_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit bad_addr(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return ((off % 4) != 0) || (off >= 4 * WORDS);
   endfunction

   function automatic int word_of(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'(off / 4);
   endfunction

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 8)       return BASE + 4 * $urandom_range(0, WORDS - 1);
      else if (r == 8) return BASE + $urandom_range(0, 4 * WORDS + 15);
      else             return $urandom;
   endfunction

   task automatic check_reset_vals(input string where);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s d%0d req_ready", where, d), o_rdy[d], 1);
         chk($sformatf("%s d%0d busy", where, d), o_busy[d], 0);
         chk($sformatf("%s d%0d resp_valid", where, d), o_vld[d], 0);
         chk($sformatf("%s d%0d resp_inst", where, d), o_inst[d], 0);
         chk($sformatf("%s d%0d resp_err", where, d), o_err[d], 0);
         pend_v[d] = 1'b0;
      end
   endtask

   // One clock cycle: drive at the falling edge, check shortly after, then advance the model.
   task automatic step(input logic rv, input logic [31:0] ra, input logic fl,
                       input logic we, input logic [31:0] wa, input logic [31:0] wd);
      bit exp_busy, exp_vld, exp_rdy;
      @(negedge clk);
      req_valid = rv; req_addr = ra; flush = fl;
      wr_en = we; wr_addr = wa; wr_data = wd;
      #1;
      for (int d = 0; d < 2; d++) begin
         exp_busy = pend_v[d] && (pend_due[d] > cyc);
         exp_vld  = pend_v[d] && (pend_due[d] == cyc);
         exp_rdy  = !exp_busy || fl;
         chk($sformatf("c%0d d%0d req_ready", cyc, d), o_rdy[d], exp_rdy);
         chk($sformatf("c%0d d%0d busy", cyc, d), o_busy[d], exp_busy);
         chk($sformatf("c%0d d%0d resp_valid", cyc, d), o_vld[d], exp_vld);
         if (exp_vld) begin
            chk($sformatf("c%0d d%0d resp_inst", cyc, d), o_inst[d], pend_inst[d]);
            chk($sformatf("c%0d d%0d resp_err", cyc, d), o_err[d], pend_err[d]);
         end
         if (rv && exp_rdy) begin
            pend_v[d]    = 1'b1;
            pend_due[d]  = cyc + 1 + wait_of[d];
            pend_err[d]  = bad_addr(ra);
            pend_inst[d] = pend_err[d] ? 32'h0 : mem_m[word_of(ra)];
         end else if (fl || exp_vld) begin
            pend_v[d] = 1'b0;
         end
      end
      if (we && !bad_addr(wa)) mem_m[word_of(wa)] = wd;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 32'h0, 32'h0);
   endtask

   task automatic fetch(input logic [31:0] a);
      step(1, a, 0, 0, 32'h0, 32'h0);
   endtask

   initial begin
      n_chk = 0; n_err = 0; cyc = 0;
      req_valid = 0; req_addr = 0; flush = 0;
      wr_en = 0; wr_addr = 0; wr_data = 0;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      #1 check_reset_vals("reset");
      repeat (2) @(posedge clk);
      #1 check_reset_vals("reset_held");
      @(negedge clk);
      resetn = 1'b1;

      // Preload every word; words 0..3 carry the back-to-back pattern.
      for (int i = 0; i < WORDS; i++)
         step(0, 32'h0, 0, 1, BASE + 4 * i, (i < 4) ? 32'h11 * (i + 1) : $urandom);
      // Bad-address writes must be dropped (they would alias word 0 if not).
      step(0, 32'h0, 0, 1, BASE + 2, 32'hbad0bad0);
      step(0, 32'h0, 0, 1, BASE + 32'h1000, 32'hbad1bad1);
      step(0, 32'h0, 0, 1, 32'h0, 32'hbad2bad2);
      idle(2);

      // Back-to-back fetches of words 0..3.
      for (int i = 0; i < 4; i++) fetch(BASE + 4 * i);
      idle(5);

      // Misaligned, beyond the array, and below the base.
      fetch(BASE + 2);            idle(4);
      fetch(BASE + 32'h1000);     idle(4);
      fetch(32'h0);               idle(4);

      // Same-cycle write and read of word 5 returns old data; the next read sees the new word.
      step(1, BASE + 20, 0, 1, BASE + 20, 32'hdead);
      idle(3);
      fetch(BASE + 20);
      idle(4);

      // Flush during the wait with a replacement fetch of word 1; then flush with no new fetch.
      fetch(BASE);
      step(1, BASE + 4, 1, 0, 32'h0, 32'h0);
      idle(5);
      fetch(BASE + 8);
      step(0, 32'h0, 1, 0, 32'h0, 32'h0);
      idle(4);
      step(0, 32'h0, 1, 0, 32'h0, 32'h0);
      idle(2);

      // Randomised traffic with flushes and concurrent preload writes.
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 9) < 7), rand_addr(), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 4) == 0), rand_addr(), $urandom);
      idle(4);

      // Asynchronous reset while the waited instance is mid-WAIT.
      fetch(BASE + 16);
      @(posedge clk);
      #2;
      req_valid = 0; flush = 0; wr_en = 0;
      resetn = 1'b0;
      #1 check_reset_vals("async_reset");
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      idle(6);
      fetch(BASE + 12);
      idle(4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/inst_rom_responder.md
# inst_rom_responder

Instruction-memory responder on the fetch side of the five-stage pipeline. The fetch stage issues a word address; this block returns the instruction one cycle later, or later when wait states are configured. It flags misaligned and out-of-range addresses, squashes an in-flight response on a pipeline flush, and provides a preload write port for the test harness.

## Interface
- `ADDR_BASE`, default 32'hbfc00000: byte address mapped to word 0 (program start address).
- `DEPTH_LOG2`, default 10: array holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, default 0: extra cycles inserted between accept and response.
- `clk`  in  1: clock, rising edge.
- `resetn`  in  1: reset. Asynchronous assert, active-low.
- `req_valid`  in  1: fetch address valid.
- `req_addr`  in  32: fetch byte address.
- `req_ready`  out  1: block can accept a request this cycle.
- `flush`  in  1: discard any accepted, not-yet-returned request (exception or taken branch).
- `resp_valid`  out  1: single-cycle pulse; `resp_inst` and `resp_err` are valid.
- `resp_inst`  out  32: instruction word; 32'h0 (NOP) when `resp_err`=1.
- `resp_err`  out  1: address misaligned or outside the array.
- `wr_en`  in  1: preload write strobe.
- `wr_addr`  in  32: preload byte address.
- `wr_data`  in  32: preload data.
- `busy`  out  1: a request is outstanding (state WAIT).

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - WAIT: `req_ready`=0, wait counter running.
  - RESP: `resp_valid`=1, `req_ready`=1.
- Accept condition: `req_valid` & `req_ready`. Latch the computed index, `err`, and state.
  - WAIT_CYCLES=0: go directly to RESP.
  - Otherwise: go to WAIT and load the counter with WAIT_CYCLES-1.
- WAIT: decrement the counter. At 0, go to RESP.
- RESP: drive the response.
  - New request accepted in the same cycle: go to RESP (WAIT_CYCLES=0) or WAIT.
  - No new request: go to IDLE.
- Offset computation: off = `req_addr` - `ADDR_BASE`, 32-bit modular subtraction.
  - index = off[DEPTH_LOG2+1:2].
  - err = (off[1:0]≠0) | (off[31:DEPTH_LOG2+2]≠0).
- On err=1: the array is not read, `resp_inst`=0, `resp_err`=1.
- The array has a synchronous read. Read is enabled on the accept cycle. With WAIT_CYCLES>0, the data is held in an output register until RESP.
- `flush`=1 in WAIT or RESP:
  - The outstanding response is cancelled and `resp_valid` stays 0.
  - Next state is IDLE, unless `req_valid` is high in the same cycle.
  - `req_ready` is forced to 1 on a flush cycle. A simultaneous new request is accepted and the old one is killed.
- `flush` in IDLE has no effect.
- Preload writes: `wr_en` writes `wr_data` at the same index rule.
  - Writes with err=1 are dropped silently.
  - A write and a read to the same index in the same cycle return the old data (read-first).
- The array contents are not reset.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_inst`=0, `resp_err`=0, `busy`=0, counter 0. Requests are ignored while `resetn`=0.
- Latency: accept at edge N gives `resp_valid` during cycle N+1+WAIT_CYCLES.
- WAIT_CYCLES=0 gives a sustained throughput of one response per cycle.
- `resp_valid` has no backpressure. The consumer must latch it in the pulse cycle.
- Reset asserted mid-WAIT or mid-RESP: the response is lost. The block is back in IDLE on the first edge after deassertion.
- `flush` takes effect at the edge it is sampled on. A `resp_valid` already high in that cycle is still shown, but the consumer must ignore it.

## Structure
- The shared package `cpu_defs_pkg` holds:
  - `STARTADDR` (32'hbfc00000)
  - `INST_NOP` (32'h0)
  - FSM enum `ifr_state_t` {IDLE, WAIT, RESP}
- One sub-module: `inst_ram_array`, a single-port synchronous-read, read-first array with a separate write port, parameterised by DEPTH_LOG2.
- The FSM, counter, address check and output register live in the top module.

## Test plan
- Back-to-back reads, WAIT_CYCLES=0: preload words 0..3 = 0x11,0x22,0x33,0x44. Request 0xbfc00000..0xbfc0000c on consecutive cycles. Expect `resp_valid` every cycle from cycle 1, data 0x11..0x44 in order.
- Address errors:
  - `req_addr`=0xbfc00002 gives `resp_err`=1, `resp_inst`=0.
  - `req_addr`=0xbfc01000 (DEPTH_LOG2=10) gives `resp_err`=1.
  - `req_addr`=0x00000000 gives `resp_err`=1.
- WAIT_CYCLES=2: request at cycle 0 gives `busy`=1 in cycles 1-2, `req_ready`=0 in cycles 1-2, `resp_valid` in cycle 3 only.
- Flush, WAIT_CYCLES=2: flush in cycle 1 gives no response for that request. A new request to 0xbfc00004 in the flush cycle returns word 1 in cycle 4.
- Write/read collision: write 0xdead to index 5 while reading index 5 in the same cycle gives the old value. A reread on the next cycle returns 0xdead.
- Reset mid-WAIT: assert `resetn`=0 asynchronously between edges. Outputs go to reset values immediately and no stale `resp_valid` appears after release.
